// File: rtl/twiddle_rom_arbiter_if.sv
// Requester-side bundle for the twiddle ROM arbiter: one request channel
// (valid/ready/addr) and one response strobe channel (no backpressure).
interface twiddle_rom_arbiter_if #(
    parameter int unsigned AW = 11,
    parameter int unsigned DW = 16
);
    logic          req_valid;
    logic [AW-1:0] req_addr;
    logic          req_ready;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;

    // Requester (e.g. FFT butterfly) side
    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data,
        input  rsp_err
    );

    // Arbiter side
    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output rsp_valid,
        output rsp_data,
        output rsp_err
    );
endinterface

// File: rtl/twiddle_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous twiddle-factor ROM between two
// requesters. Each accepted read carries a {port, err} tag down a pipeline that
// matches the ROM latency, so rom_dout is steered back to the issuing port.
module twiddle_rom_arbiter #(
    parameter int unsigned ROM_LATENCY = 2,    // 1..4
    parameter int unsigned MAX_ADDR    = 1024,
    parameter int unsigned AW          = 11,
    parameter int unsigned DW          = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    twiddle_rom_arbiter_if.slave  port0,
    twiddle_rom_arbiter_if.slave  port1,
    output logic                  rom_ce,
    output logic                  rom_oce,
    output logic [AW-1:0]         rom_ad,
    input  logic [DW-1:0]         rom_dout
);

    typedef struct packed {
        logic vld;
        logic port;
        logic err;
    } tag_t;

    logic          last_q;     // last granted port; 1 after reset so port 0 wins first
    logic [AW-1:0] rom_ad_q;
    logic          gnt0;
    logic          gnt1;
    logic          accept;
    logic [AW-1:0] sel_addr;
    logic          sel_err;
    tag_t          new_tag;
    tag_t          tag_out;

    // Stage 0 is aligned with rom_ad; the remaining ROM_LATENCY stages follow
    // the ROM's internal pipeline, so the last stage lines up with rom_dout.
    tag_t [ROM_LATENCY:0] tag_q;

    logic          rsp0_valid_q;
    logic [DW-1:0] rsp0_data_q;
    logic          rsp0_err_q;
    logic          rsp1_valid_q;
    logic [DW-1:0] rsp1_data_q;
    logic          rsp1_err_q;

    // Grant: a lone requester always wins; on contention the port that was not
    // granted last wins.
    always_comb begin
        gnt0     = port0.req_valid && (!port1.req_valid || last_q);
        gnt1     = port1.req_valid && (!port0.req_valid || !last_q);
        accept   = gnt0 || gnt1;
        sel_addr = gnt1 ? port1.req_addr : port0.req_addr;
        sel_err  = sel_addr > AW'(MAX_ADDR);
        new_tag  = tag_t'{vld: accept, port: gnt1, err: accept && sel_err};
        tag_out  = tag_q[ROM_LATENCY];
    end

    assign port0.req_ready = gnt0;
    assign port1.req_ready = gnt1;

    // ROM is free-running whenever out of reset.
    assign rom_ce  = ~reset;
    assign rom_oce = ~reset;
    assign rom_ad  = rom_ad_q;

    // Issue stage: pointer and ROM address move only on an accepted request;
    // out-of-range indices read entry 0 instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q   <= 1'b1;
            rom_ad_q <= '0;
        end else if (accept) begin
            last_q   <= gnt1;
            rom_ad_q <= sel_err ? '0 : sel_addr;
        end
    end

    // Tag pipeline shifts every cycle; idle cycles push empty tags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_q <= '0;
        end else begin
            tag_q <= {tag_q[ROM_LATENCY-1:0], new_tag};
        end
    end

    // Response registers: one-cycle strobe to the tagged port; data/err hold
    // their last value while the strobe is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp0_valid_q <= 1'b0;
            rsp0_data_q  <= '0;
            rsp0_err_q   <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp1_data_q  <= '0;
            rsp1_err_q   <= 1'b0;
        end else begin
            rsp0_valid_q <= tag_out.vld && !tag_out.port;
            rsp1_valid_q <= tag_out.vld && tag_out.port;
            if (tag_out.vld && !tag_out.port) begin
                rsp0_data_q <= tag_out.err ? '0 : rom_dout;
                rsp0_err_q  <= tag_out.err;
            end
            if (tag_out.vld && tag_out.port) begin
                rsp1_data_q <= tag_out.err ? '0 : rom_dout;
                rsp1_err_q  <= tag_out.err;
            end
        end
    end

    assign port0.rsp_valid = rsp0_valid_q;
    assign port0.rsp_data  = rsp0_data_q;
    assign port0.rsp_err   = rsp0_err_q;
    assign port1.rsp_valid = rsp1_valid_q;
    assign port1.rsp_data  = rsp1_data_q;
    assign port1.rsp_err   = rsp1_err_q;

endmodule

// File: doc/twiddle_rom_arbiter.md
Name: twiddle_rom_arbiter

Overview:
- Shares one twiddle-factor synchronous ROM between two requesters, e.g. FFT butterfly and IFFT/equaliser stage.
- ROM: 11-bit address, 16-bit data, ce/oce enables, active-high reset, registered output.
- Round-robin arbitration of per-port valid/ready requests; ROM data is returned to the issuing port after a fixed pipeline latency.
- Sits between the requesters and the ROM instance; the ROM is instantiated outside this block.

Parameters:
- ROM_LATENCY, 2, clock edges from address issue to valid rom_dout; legal range 1..4.
- MAX_ADDR, 1024, highest legal table index; table holds MAX_ADDR+1 entries.
- AW, 11, address width.
- DW, 16, data width.

Ports:
- clk  in  1  system clock (27 MHz).
- reset  in  1  asynchronous active-high reset.
- req0_valid  in  1  port 0 request.
- req0_addr  in  AW  port 0 table index.
- req0_ready  out  1  port 0 request accepted this cycle.
- rsp0_valid  out  1  port 0 response strobe.
- rsp0_data  out  DW  port 0 twiddle word.
- rsp0_err  out  1  port 0 response was out of range.
- req1_valid, req1_addr, req1_ready, rsp1_valid, rsp1_data, rsp1_err: same as port 0, for port 1.
- rom_ce  out  1  ROM clock enable.
- rom_oce  out  1  ROM output-register enable.
- rom_ad  out  AW  ROM address.
- rom_dout  in  DW  ROM data.

Behaviour:
- Reset: all outputs 0; last-grant pointer = 1 so port 0 wins first; in-flight pipeline cleared.
- Reset asserted mid-operation drops all in-flight reads; no response is emitted for them.
- reqN_ready is combinational from the valid inputs and the pointer; a request is accepted when valid && ready.
- Arbitration:
  - Only one valid: that port is granted.
  - Both valid: grant the port other than the last granted.
  - Pointer updates only on an accepted request.
- Throughput: one accepted request per cycle; no bubbles under back-to-back traffic.
- Accept cycle (registered on the clock edge):
  - rom_ad <= addr.
  - Push tag {port, err} into a ROM_LATENCY-deep shift register with a valid bit.
  - err = (addr > MAX_ADDR).
  - If err, rom_ad <= 0.
- rom_ce and rom_oce are held at 1 whenever reset is low. The ROM is free-running; unmatched rom_dout is ignored.
- Response timing: tag exits the shift register ROM_LATENCY cycles after rom_ad updates, i.e. ROM_LATENCY+1 cycles after the accept edge.
- Response contents for the port in the tag:
  - rspN_valid = 1 for one cycle.
  - rspN_data = err ? 0 : rom_dout.
  - rspN_err = err.
  - Other port's rsp outputs hold valid = 0.
- rsp data/err outputs hold their last value when valid = 0.
- Responses have no backpressure; requesters must always accept them.
- Ordering: responses return per port in issue order, and globally in issue order.
- Address MAX_ADDR is legal; MAX_ADDR+1 and above are errors. No wrap-around of out-of-range indices.
- Idle (no valid inputs): rom_ad holds its value; shift register shifts in empty tags.

Test Plan:
- Reset held, then released with no requests -> all rsp*_valid = 0, rom_ce = rom_oce = 1, rom_ad = 0 for 20 cycles.
- Port 0 only, addresses 0..1024 back-to-back -> req0_ready = 1 every cycle; rsp0_valid asserted 1025 consecutive cycles starting 3 cycles after the first accept; rsp0_data equals the golden ROM image per address.
- Both valid every cycle (port 0 addr 5, port 1 addr 700) -> grants alternate 0,1,0,1 starting with port 0; each port's rsp_valid toggles; data = rom[5] and rom[700] respectively.
- Port 1 addr 1025 and addr 2047 -> rom_ad = 0; rsp1_err = 1 and rsp1_data = 0 for both; addr 1024 -> err = 0 with correct data.
- Reset asserted 1 cycle after 3 accepts -> no rsp*_valid pulse during or after reset for those requests; first request after release is granted to port 0.
- ROM_LATENCY = 1 build, single request at addr 100 -> rsp0_valid exactly 2 cycles after the accept edge with rom[100].
